// File: rtl/rv32i_control_fsm.sv
// rtl/rv32i_control_fsm.sv - multi-cycle RV32I control sequencer
// Handshake/status outputs are registered from next state; datapath strobes are decoded from current state.
module rv32i_control_fsm #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             isALUreg,
    input  logic             isALUimm,
    input  logic             isBranch,
    input  logic             isJALR,
    input  logic             isJAL,
    input  logic             isAUIPC,
    input  logic             isLUI,
    input  logic             isLoad,
    input  logic             isStore,
    input  logic             isSYSTEM,
    input  logic             rd_zero,
    input  logic             take_branch,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_we,
    output logic             rdata_we,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic [2:0]       state,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             halted,
    output logic             trap
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_HALT    = 3'd6,
        S_TRAP    = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        C_NONE   = 3'd0,
        C_SYS    = 3'd1,
        C_LOAD   = 3'd2,
        C_STORE  = 3'd3,
        C_JALR   = 3'd4,
        C_JAL    = 3'd5,
        C_BRANCH = 3'd6,
        C_ALU    = 3'd7
    } cls_e;

    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

    state_e            state_q, state_d;
    cls_e              cls_q, cls_d, cls_dec;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic              addr_sel_q, addr_sel_d;
    logic              halted_q, halted_d;
    logic              trap_q, trap_d;
    logic              mem_wait, to_expire;

    // Class priority when the decoder raises several flags at once.
    always_comb begin
        cls_dec = C_NONE;
        if (isSYSTEM)                                  cls_dec = C_SYS;
        else if (isLoad)                               cls_dec = C_LOAD;
        else if (isStore)                              cls_dec = C_STORE;
        else if (isJALR)                               cls_dec = C_JALR;
        else if (isJAL)                                cls_dec = C_JAL;
        else if (isBranch)                             cls_dec = C_BRANCH;
        else if (isALUreg || isALUimm || isLUI || isAUIPC) cls_dec = C_ALU;
    end

    assign mem_wait  = mem_req_q && !mem_ready;
    assign to_expire = (TIMEOUT != 0) && mem_wait && (to_cnt_q == TO_LAST);

    always_comb begin
        state_d  = state_q;
        cls_d    = cls_q;
        ir_we    = 1'b0;
        rdata_we = 1'b0;
        rf_we    = 1'b0;
        wb_sel   = 2'd0;
        pc_we    = 1'b0;
        pc_sel   = 2'd0;
        retire   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (to_expire) begin
                    state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                cls_d = cls_dec;
                case (cls_dec)
                    C_NONE:  state_d = S_TRAP;
                    C_SYS:   state_d = S_HALT;
                    default: state_d = S_EXECUTE;
                endcase
            end
            S_EXECUTE: begin
                state_d = S_FETCH;
                case (cls_q)
                    C_LOAD, C_STORE: state_d = S_MEM;
                    C_ALU, C_JAL, C_JALR: begin
                        rf_we  = !rd_zero;
                        wb_sel = (cls_q == C_ALU) ? 2'd0 : 2'd2;
                        pc_we  = 1'b1;
                        pc_sel = (cls_q == C_JALR) ? 2'd2 : ((cls_q == C_JAL) ? 2'd1 : 2'd0);
                        retire = 1'b1;
                    end
                    C_BRANCH: begin
                        pc_we  = 1'b1;
                        pc_sel = take_branch ? 2'd1 : 2'd0;
                        retire = 1'b1;
                    end
                    default: state_d = S_TRAP;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (cls_q == C_STORE) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        rdata_we = 1'b1;
                        state_d  = S_WB;
                    end
                end else if (to_expire) begin
                    state_d = S_TRAP;
                end
            end
            S_WB: begin
                rf_we   = !rd_zero;
                wb_sel  = 2'd1;
                pc_we   = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = state_q;
        endcase
    end

    // Registered handshake outputs follow the state being entered so they align with state_q.
    always_comb begin
        mem_req_d  = (state_d == S_FETCH) || (state_d == S_MEM);
        addr_sel_d = (state_d == S_MEM);
        mem_we_d   = (state_d == S_MEM) && (cls_d == C_STORE);
        halted_d   = (state_d == S_HALT);
        trap_d     = (state_d == S_TRAP);
        instret_d  = instret_q + CNT_W'(retire);
        to_cnt_d   = to_cnt_q;
        if (state_d != state_q)
            to_cnt_d = '0;
        else if (mem_wait && (TIMEOUT != 0))
            to_cnt_d = to_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cls_q      <= C_NONE;
            to_cnt_q   <= '0;
            instret_q  <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            addr_sel_q <= 1'b0;
            halted_q   <= 1'b0;
            trap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cls_q      <= cls_d;
            to_cnt_q   <= to_cnt_d;
            instret_q  <= instret_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            addr_sel_q <= addr_sel_d;
            halted_q   <= halted_d;
            trap_q     <= trap_d;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_we   = mem_we_q;
    assign addr_sel = addr_sel_q;
    assign state    = state_q;
    assign instret  = instret_q;
    assign halted   = halted_q;
    assign trap     = trap_q;

endmodule

// File: tb/tb_rv32i_control_fsm.sv
// tb/tb_rv32i_control_fsm.sv - randomized instruction-level bench for rv32i_control_fsm
module tb_rv32i_control_fsm;

    localparam int TO = 4;
    localparam int CW = 4;
    localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2, ST_EXECUTE = 3'd3,
                           ST_MEM = 3'd4, ST_WB = 3'd5, ST_HALT = 3'd6, ST_TRAP = 3'd7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run = 1'b0;
    logic [9:0] flags = '0;
    logic rd_zero = 1'b0, take_branch = 1'b0, mem_ready = 1'b0;
    logic mem_req, mem_we, addr_sel, ir_we, rdata_we, rf_we, pc_we, retire, halted, trap;
    logic [1:0] wb_sel, pc_sel;
    logic [2:0] state;
    logic [CW-1:0] instret;

    int total = 0;
    int bad = 0;
    int exp_instret = 0;

    rv32i_control_fsm #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .isALUreg(flags[0]), .isALUimm(flags[1]), .isBranch(flags[2]), .isJALR(flags[3]),
        .isJAL(flags[4]), .isAUIPC(flags[5]), .isLUI(flags[6]), .isLoad(flags[7]),
        .isStore(flags[8]), .isSYSTEM(flags[9]),
        .rd_zero(rd_zero), .take_branch(take_branch), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we),
        .rdata_we(rdata_we), .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel),
        .state(state), .retire(retire), .instret(instret), .halted(halted), .trap(trap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drops reset mid-cycle, checks the async clear, and rearms with run high.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, "_outs"}, {mem_req, mem_we, addr_sel, ir_we, rdata_we, rf_we, wb_sel,
                               pc_we, pc_sel, retire, halted, trap}, 0);
        check({tag, "_state"}, state, ST_IDLE);
        check({tag, "_instret"}, instret, 0);
        exp_instret = 0;
        @(negedge clk);
        rst_n = 1'b1;
        run   = 1'b1;
    endtask

    // Runs one instruction from FETCH; expectations come from the instruction class and stall counts.
    task automatic run_instr(input logic [9:0] f, input logic rdz, input logic tb,
                             input int fs, input int ms);
        int cls;
        logic [2:0] es[$];
        bit retires = 0, exp_halt = 0, exp_trap = 0;
        int exp_rf = 0, exp_rd = 0, exp_ir = 0, exp_pcsel = 0, exp_wbsel = 0, exp_req = 0, exp_we = 0;
        int g_rf = 0, g_rd = 0, g_ir = 0, g_pcwe = 0, g_ret = 0, g_req = 0, g_we = 0;
        int g_pcsel = 0, g_wbsel = 0, fc = 0, mc = 0;
        string tg;

        if (f[9])                        cls = 1;
        else if (f[7])                   cls = 2;
        else if (f[8])                   cls = 3;
        else if (f[3])                   cls = 4;
        else if (f[4])                   cls = 5;
        else if (f[2])                   cls = 6;
        else if (f[0] | f[1] | f[5] | f[6]) cls = 7;
        else                             cls = 0;

        if (fs >= TO) begin
            repeat (TO) es.push_back(ST_FETCH);
            exp_req  = TO;
            exp_trap = 1;
        end else begin
            repeat (fs + 1) es.push_back(ST_FETCH);
            exp_req = fs + 1;
            exp_ir  = 1;
            es.push_back(ST_DECODE);
            if (cls == 0) exp_trap = 1;
            else if (cls == 1) exp_halt = 1;
            else begin
                es.push_back(ST_EXECUTE);
                if (cls == 2 || cls == 3) begin
                    if (ms >= TO) begin
                        repeat (TO) es.push_back(ST_MEM);
                        exp_req += TO;
                        if (cls == 3) exp_we = TO;
                        exp_trap = 1;
                    end else begin
                        repeat (ms + 1) es.push_back(ST_MEM);
                        exp_req += ms + 1;
                        retires = 1;
                        if (cls == 3) exp_we = ms + 1;
                        else begin
                            exp_rd    = 1;
                            es.push_back(ST_WB);
                            exp_rf    = !rdz;
                            exp_wbsel = 1;
                        end
                    end
                end else begin
                    retires = 1;
                    if (cls == 6) exp_pcsel = tb;
                    else begin
                        exp_rf    = !rdz;
                        exp_wbsel = (cls == 7) ? 0 : 2;
                        exp_pcsel = (cls == 7) ? 0 : ((cls == 5) ? 1 : 2);
                    end
                end
            end
        end
        if (exp_trap) es.push_back(ST_TRAP);
        if (exp_halt) es.push_back(ST_HALT);

        flags = f;
        rd_zero = rdz;
        take_branch = tb;
        tg = $sformatf("c%0d_f%0d_m%0d", cls, fs, ms);
        for (int i = 0; i < es.size(); i++) begin
            @(posedge clk);
            #1;
            if (mem_req) begin
                if (!addr_sel) begin mem_ready = (fc == fs); fc++; end
                else begin mem_ready = (mc == ms); mc++; end
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            if (i == 0) check({tg, "_instret"}, instret, exp_instret);
            check($sformatf("%s_state%0d", tg, i), state, es[i]);
            g_ir  += ir_we;
            g_rd  += rdata_we;
            g_ret += retire;
            g_req += mem_req;
            g_we  += (mem_req && mem_we);
            if (rf_we) begin g_rf++; g_wbsel = wb_sel; end
            if (pc_we) begin g_pcwe++; g_pcsel = pc_sel; end
        end
        check({tg, "_ir_we"}, g_ir, exp_ir);
        check({tg, "_rdata_we"}, g_rd, exp_rd);
        check({tg, "_rf_we"}, g_rf, exp_rf);
        check({tg, "_pc_we"}, g_pcwe, retires);
        check({tg, "_retire"}, g_ret, retires);
        check({tg, "_req_cycles"}, g_req, exp_req);
        check({tg, "_we_cycles"}, g_we, exp_we);
        check({tg, "_halted"}, halted, exp_halt);
        check({tg, "_trap"}, trap, exp_trap);
        if (retires) check({tg, "_pc_sel"}, g_pcsel, exp_pcsel);
        if (exp_rf != 0) check({tg, "_wb_sel"}, g_wbsel, exp_wbsel);
        if (exp_trap || exp_halt) check({tg, "_req_end"}, mem_req, 0);
        if (retires) exp_instret = (exp_instret + 1) % (1 << CW);
        if (exp_trap || exp_halt) do_reset({tg, "_rst"});
    endtask

    initial begin
        logic [9:0] f;
        int r;
        bit found;

        repeat (2) @(posedge clk);
        #1;
        check("por_outs", {mem_req, mem_we, addr_sel, ir_we, rdata_we, rf_we, wb_sel,
                           pc_we, pc_sel, retire, halted, trap, state}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            check("idle_hold", {state, mem_req}, {ST_IDLE, 1'b0});
        end
        run = 1'b1;

        run_instr(10'h002, 0, 0, 0, 0);     // ALUimm rd=5
        run_instr(10'h080, 0, 0, 0, 2);     // load, two stall cycles in MEM
        run_instr(10'h004, 0, 1, 0, 0);     // branch taken
        run_instr(10'h004, 0, 0, 1, 0);     // branch not taken
        run_instr(10'h001, 1, 0, 0, 0);     // ALUreg to x0
        run_instr(10'h010, 0, 0, 2, 0);     // JAL
        run_instr(10'h008, 0, 0, 0, 0);     // JALR
        run_instr(10'h100, 0, 0, 0, 3);     // store, ready on last allowed cycle
        run_instr(10'h002, 0, 0, 3, 0);     // fetch ready on last allowed cycle
        run_instr(10'h002, 0, 0, 4, 0);     // fetch timeout
        run_instr(10'h000, 0, 0, 0, 0);     // no class flag
        run_instr(10'h201, 0, 0, 0, 0);     // SYSTEM wins priority
        run_instr(10'h180, 0, 0, 0, 5);     // load wins over store, MEM timeout
        for (int i = 0; i < 20; i++) run_instr(10'h040, 0, 0, 0, 0);   // instret wrap

        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 19);
            if (r == 0) f = '0;
            else if (r < 3) f = 10'($urandom);
            else f = 10'b1 << $urandom_range(0, 9);
            run_instr(f, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 15) == 0) ? 4 + $urandom_range(0, 1) : $urandom_range(0, 3),
                      ($urandom_range(0, 15) == 0) ? 4 + $urandom_range(0, 1) : $urandom_range(0, 3));
        end

        run_instr(10'h002, 0, 0, 0, 0);
        run_instr(10'h002, 0, 0, 0, 0);
        flags = 10'h080;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            #1;
            mem_ready = mem_req && !addr_sel;
            #1;
            found = mem_req && addr_sel;
        end
        check("mid_mem_reached", found, 1);
        do_reset("mid_mem");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv32i_control_fsm.md
Name: rv32i_control_fsm

Overview:
- Multi-cycle sequencer for the RV32I core. Consumes the instruction decoder's opcode-class flags plus the branch comparator result.
- Drives instruction/data memory handshakes, the instruction-register load, register-file write, PC update and writeback mux selects.
- Sits between the memory interface, the decoder and the PC/ALU/register-file datapath.
- Detects illegal opcodes, SYSTEM instructions and memory timeouts, and counts retired instructions.

Parameters:
- TIMEOUT, 16, max cycles a memory request waits for mem_ready before trapping. 0 disables the timeout.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; leaves IDLE when high.
- isALUreg, isALUimm, isBranch, isJALR, isJAL, isAUIPC, isLUI, isLoad, isStore, isSYSTEM  in  1 each  decoder class flags; valid from DECODE onward.
- rd_zero  in  1  decoded rdId == 0.
- take_branch  in  1  comparator result; valid in EXECUTE.
- mem_ready  in  1  memory accepts/completes the current request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  write strobe; qualified by mem_req.
- addr_sel  out  1  0 = PC, 1 = ALU result.
- ir_we  out  1  load instruction register.
- rdata_we  out  1  capture load data.
- rf_we  out  1  register-file write.
- wb_sel  out  2  0 = ALU, 1 = memory data, 2 = PC+4.
- pc_we  out  1  update PC.
- pc_sel  out  2  0 = PC+4, 1 = PC+imm, 2 = ALU result (JALR).
- state  out  3  current state encoding, for debug.
- retire  out  1  one-cycle pulse per completed instruction.
- instret  out  CNT_W  retired-instruction count.
- halted  out  1  in HALT.
- trap  out  1  in TRAP.

Behaviour:
- Reset (async, rst_n low): state = IDLE; all outputs 0; instret = 0; timeout counter = 0. Applies immediately, including mid-request; mem_req drops with no completion.
- Outputs are Moore-decoded from state, except pulses qualified by mem_ready or decoder flags as listed below.
- IDLE: wait; run = 1 → FETCH.
- FETCH: mem_req = 1, mem_we = 0, addr_sel = 0. On mem_ready: ir_we = 1 (same cycle) → DECODE.
- DECODE:
  - no class flag set → TRAP;
  - isSYSTEM → HALT (ecall and ebreak both halt; no retire);
  - otherwise → EXECUTE.
- EXECUTE:
  - ALUreg/ALUimm/LUI/AUIPC: rf_we = !rd_zero, wb_sel = 0, pc_we = 1, pc_sel = 0, retire → FETCH.
  - JAL: rf_we = !rd_zero, wb_sel = 2, pc_we, pc_sel = 1, retire → FETCH.
  - JALR: as JAL but pc_sel = 2.
  - Branch: pc_we = 1, pc_sel = take_branch ? 1 : 0, rf_we = 0, retire → FETCH.
  - Load/Store → MEM.
- MEM: mem_req = 1, addr_sel = 1, mem_we = isStore. On mem_ready:
  - store: pc_we, pc_sel = 0, retire → FETCH;
  - load: rdata_we = 1 → WB.
- WB: rf_we = !rd_zero, wb_sel = 1, pc_we, pc_sel = 0, retire → FETCH.
- HALT, TRAP: absorbing; only reset exits. run is ignored outside IDLE.
- Latency with mem_ready already high: ALU/jump/branch 3 cycles, store 4, load 5. Each cycle of mem_ready low adds one cycle.
- Handshake: mem_req is held, with stable mem_we/addr_sel, until the cycle mem_ready = 1. mem_ready outside FETCH/MEM is ignored.
- Timeout: counter clears on entering FETCH/MEM and increments each cycle mem_req = 1 and mem_ready = 0. Reaching TIMEOUT → TRAP next edge, with mem_req low in TRAP. mem_ready in the same cycle the count reaches TIMEOUT wins (completion, no trap).
- instret: increments on the retire cycle; wraps modulo 2^CNT_W silently.
- Multiple class flags asserted simultaneously: priority SYSTEM > Load > Store > JALR > JAL > Branch > ALU/LUI/AUIPC.

Test Plan:
- Reset, run = 1, mem_ready tied 1, ALUimm with rd = 5 → states IDLE, FETCH, DECODE, EXECUTE; rf_we and pc_we high in cycle 3; instret = 1.
- Load, mem_ready low 2 cycles in MEM → mem_req held 3 cycles; rdata_we once; WB rf_we, wb_sel = 1; total 7 cycles.
- Branch with take_branch = 1 then 0 → pc_sel = 1 then 0; rf_we never asserted; instret += 2.
- ALUreg with rd_zero = 1 → rf_we stays 0, pc_we = 1, retire = 1.
- TIMEOUT = 4, mem_ready held 0 in FETCH → trap after 4 request cycles, mem_req = 0 after; mem_ready on cycle 4 instead → DECODE, no trap.
- All flags 0 → TRAP from DECODE; isSYSTEM → HALT, instret unchanged.
- rst_n low mid-MEM → async IDLE, outputs 0, instret = 0.
